// File: rtl/sha256_nonce_sched_pkg.sv
// sha256_nonce_sched_pkg: scan state encoding, SHA-256 padding constants and second-block builder
package sha256_nonce_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD = 32'h0000_0280;
  localparam int NONCE_WORD = 3;
  function automatic int unsigned word_lsb(input int unsigned w);
    return 32 * w;
  endfunction
  // Second 64-byte block of an 80-byte header: three tail words, the nonce,
  // the 0x80 pad byte and the 640-bit message length.
  function automatic logic [511:0] build_block(input logic [95:0] tail, input logic [31:0] nonce);
    logic [511:0] b;
    b = '0;
    for (int w = 0; w < 3; w++) b[word_lsb(w) +: 32] = tail[32*w +: 32];
    b[word_lsb(NONCE_WORD) +: 32] = nonce;
    b[word_lsb(4) +: 32] = PAD_WORD;
    b[word_lsb(15) +: 32] = LEN_WORD;
    return b;
  endfunction
endpackage

// File: rtl/sha256_nonce_sched_fifo.sv
// sha256_nonce_fifo: synchronous FIFO holding found nonces
// Ports: clk, rst_n (async active-low); push_i/data_i write side; pop_i/data_o read side;
//        full_o/empty_o status. A push on a full FIFO succeeds when a pop happens in the same cycle.
module sha256_nonce_fifo
  import sha256_nonce_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head reads as zero when empty so the output is clean out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: feeds a nonce range into a pipelined SHA-256 core and queues nonces whose hash top word is zero
// Ports: clk, rst_n (async active-low); start_i/abort_i control; midstate_i, data_tail_i,
//        nonce_first_i, nonce_last_i scan setup (latched on accepted start);
//        pipe_state_o/pipe_data_o/issue_valid_o to the hash pipe, pipe_hash_i back from it;
//        busy_o, done_o status; found_valid_o/found_ready_i/found_nonce_o result queue head; overflow_o sticky drop flag.
module sha256_nonce_sched
  import sha256_nonce_sched_pkg::*;
#(
  parameter int PIPE_LATENCY = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  data_tail_i,
  input  logic [31:0]  nonce_first_i,
  input  logic [31:0]  nonce_last_i,
  output logic [255:0] pipe_state_o,
  output logic [511:0] pipe_data_o,
  output logic         issue_valid_o,
  input  logic [255:0] pipe_hash_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         found_valid_o,
  input  logic         found_ready_i,
  output logic [31:0]  found_nonce_o,
  output logic         overflow_o
);
  localparam int CW = $clog2(PIPE_LATENCY + 1);
  state_e state_q;
  logic busy_q, done_q, ovf_q, ovf_d;
  logic [255:0] mid_q;
  logic [95:0] tail_q;
  logic [31:0] nonce_q;
  logic [32:0] rem_q;
  logic [CW-1:0] drain_q;
  logic [PIPE_LATENCY-1:0] vld_q;
  logic [31:0] nd_q [PIPE_LATENCY];
  logic start_ok, issue, hit, pop, push, drop, fifo_full, fifo_empty, unused_hash;
  assign start_ok = start_i & ~abort_i & (state_q == ST_IDLE || state_q == ST_DONE);
  assign issue    = state_q == ST_RUN;
  // Results still in the pipe when abort arrives are discarded, including the one at the tap now.
  assign hit      = vld_q[PIPE_LATENCY-1] & ~abort_i & (pipe_hash_i[255:224] == 32'd0);
  assign pop      = ~fifo_empty & found_ready_i;
  assign drop     = hit & fifo_full & ~pop;
  assign push     = hit & ~drop;
  assign ovf_d    = (start_ok ? 1'b0 : ovf_q) | drop;
  assign unused_hash = ^pipe_hash_i[223:0];
  assign issue_valid_o = issue;
  assign pipe_state_o  = mid_q;
  assign pipe_data_o   = issue ? build_block(tail_q, nonce_q) : '0;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_valid_o = ~fifo_empty;
  assign overflow_o    = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mid_q   <= '0;
      tail_q  <= '0;
      nonce_q <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= ovf_d;
      if (abort_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        rem_q   <= '0;
      end else if (start_ok) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
        mid_q   <= midstate_i;
        tail_q  <= data_tail_i;
        nonce_q <= nonce_first_i;
        // 33 bits so that last == first - 1 counts the full 2^32 range.
        rem_q   <= {1'b0, nonce_last_i - nonce_first_i} + 33'd1;
      end else if (state_q == ST_RUN) begin
        nonce_q <= nonce_q + 32'd1;
        rem_q   <= rem_q - 33'd1;
        if (rem_q == 33'd1) begin
          state_q <= ST_DRAIN;
          drain_q <= CW'(PIPE_LATENCY - 1);
        end
      end else if (state_q == ST_DRAIN) begin
        if (drain_q == '0) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q - CW'(1);
        end
      end
    end
  end
  // Valid bits travel alongside the hash pipe so each result tap knows whether it is real.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (abort_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= issue;
      for (int i = 1; i < PIPE_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    nd_q[0] <= nonce_q;
    for (int i = 1; i < PIPE_LATENCY; i++) nd_q[i] <= nd_q[i-1];
  end
  sha256_nonce_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (nd_q[PIPE_LATENCY-1]),
    .pop_i   (pop),
    .data_o  (found_nonce_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_sha256_nonce_sched.sv
// tb_sha256_nonce_sched: directed/random scans against a toy hash pipe and a queue-level result model
module tb_sha256_nonce_sched;
  localparam int PL = 8;
  localparam int FD = 4;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, found_ready_i = 1'b0;
  logic [255:0] midstate_i = '0;
  logic [95:0] data_tail_i = '0;
  logic [31:0] nonce_first_i = '0, nonce_last_i = '0;
  logic [255:0] pipe_state_o, pipe_hash_i;
  logic [511:0] pipe_data_o;
  logic issue_valid_o, busy_o, done_o, found_valid_o, overflow_o;
  logic [31:0] found_nonce_o;
  int errors = 0, checks = 0;
  logic [31:0] hit_lo = 32'h1, hit_hi = 32'h0;
  bit force_all = 1'b0;
  logic [31:0] exp_q [$];
  bit exp_ovf = 1'b0;
  logic [511:0] pd [PL] = '{default: '0};
  logic [31:0] pn;

  sha256_nonce_sched #(.PIPE_LATENCY(PL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .midstate_i(midstate_i), .data_tail_i(data_tail_i),
    .nonce_first_i(nonce_first_i), .nonce_last_i(nonce_last_i),
    .pipe_state_o(pipe_state_o), .pipe_data_o(pipe_data_o), .issue_valid_o(issue_valid_o),
    .pipe_hash_i(pipe_hash_i), .busy_o(busy_o), .done_o(done_o),
    .found_valid_o(found_valid_o), .found_ready_i(found_ready_i),
    .found_nonce_o(found_nonce_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Stand-in for the external SHA pipe: PL register stages, top hash word zero on chosen nonces.
  always @(posedge clk) begin
    pd[0] <= pipe_data_o;
    for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
  end
  always_comb begin
    pn = pd[PL-1][127:96];
    pipe_hash_i = {(force_all || (pn >= hit_lo && pn <= hit_hi)) ? 32'h0 : ((pn ^ 32'h5A5A5A5A) | 32'h1), pd[PL-1][223:0]};
  end

  function automatic bit is_hit(input logic [31:0] n);
    return n >= hit_lo && n <= hit_hi;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [31:0] first, input logic [31:0] last, input bit pulse,
                          input bit restart, input string tag);
    int n, lat, bcnt;
    logic [31:0] got [$];
    logic [255:0] mid;
    n = int'(last - first) + 1;
    lat = -1;
    bcnt = 0;
    mid = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    midstate_i = mid;
    data_tail_i = {$urandom(), $urandom(), $urandom()};
    nonce_first_i = first;
    nonce_last_i = last;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, ".pipe_state"}, pipe_state_o, mid);
    for (int k = 0; k < n + PL + 16; k++) begin
      if (k > 0) @(negedge clk);
      if (issue_valid_o) begin
        chk({tag, ".pipe_data"}, pipe_data_o,
            {32'h0000_0280, 320'd0, 32'h8000_0000, first + 32'(got.size()), data_tail_i});
        got.push_back(pipe_data_o[127:96]);
      end
      if (busy_o) bcnt++;
      if (done_o) begin
        lat = k;
        break;
      end
      found_ready_i = pulse && k >= PL && (k - PL) < n && is_hit(first + 32'(k - PL));
      start_i = restart && k == 1;
      if (restart && k == 1) nonce_first_i = 32'hDEAD_0000;
    end
    found_ready_i = 1'b0;
    start_i = 1'b0;
    chk({tag, ".done_latency"}, lat, n + PL);
    chk({tag, ".busy_cycles"}, bcnt, n + PL);
    chk({tag, ".issued_count"}, got.size(), n);
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (is_hit(first + 32'(i))) begin
        if (pulse) void'(exp_q.pop_front());
        if (exp_q.size() < FD) exp_q.push_back(first + 32'(i));
        else exp_ovf = 1'b1;
      end
    end
    chk({tag, ".overflow"}, overflow_o, exp_ovf);
    @(negedge clk);
    chk({tag, ".done_pulse_width"}, done_o, 1'b0);
  endtask

  task automatic drain_check(input string tag);
    logic [31:0] e;
    found_ready_i = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".found_valid"}, found_valid_o, 1'b1);
      chk({tag, ".found_nonce"}, found_nonce_o, e);
      @(negedge clk);
    end
    chk({tag, ".empty_after"}, found_valid_o, 1'b0);
    found_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen_done, seen_fv, seen_busy;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.done", done_o, 1'b0);
    chk("rst.found_valid", found_valid_o, 1'b0);
    chk("rst.found_nonce", found_nonce_o, 32'd0);
    chk("rst.overflow", overflow_o, 1'b0);
    chk("rst.pipe_data", pipe_data_o, 512'd0);
    chk("rst.pipe_state", pipe_state_o, 256'd0);
    chk("rst.issue_valid", issue_valid_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    nonce_first_i = 32'h5;
    nonce_last_i = 32'h9;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort.busy", busy_o, 1'b0);
    chk("start_abort.issue", issue_valid_o, 1'b0);

    hit_lo = 32'h12;
    hit_hi = 32'h12;
    run_scan(32'h10, 32'h13, 1'b0, 1'b0, "single_hit");
    drain_check("single_hit");

    hit_lo = 32'h1;
    hit_hi = 32'h0;
    run_scan(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, "wrap");
    drain_check("wrap");

    hit_lo = 32'h102;
    hit_hi = 32'h107;
    run_scan(32'h100, 32'h109, 1'b0, 1'b0, "overflow");
    for (int i = 0; i < 3; i++) begin
      chk("overflow.stable_head", found_nonce_o, exp_q[0]);
      @(negedge clk);
    end
    drain_check("overflow");

    hit_lo = 32'h200;
    hit_hi = 32'h203;
    run_scan(32'h200, 32'h203, 1'b0, 1'b0, "fill");
    hit_lo = 32'h302;
    hit_hi = 32'h303;
    run_scan(32'h300, 32'h305, 1'b1, 1'b0, "push_pop_full");
    drain_check("push_pop_full");

    force_all = 1'b1;
    @(negedge clk);
    nonce_first_i = 32'd0;
    nonce_last_i = 32'd100;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort.busy", busy_o, 1'b0);
    chk("abort.issue", issue_valid_o, 1'b0);
    seen_done = 1'b0;
    seen_fv = 1'b0;
    repeat (2 * PL + 4) begin
      @(negedge clk);
      seen_done |= done_o;
      seen_fv |= found_valid_o;
    end
    chk("abort.no_done", seen_done, 1'b0);
    chk("abort.no_hits", seen_fv, 1'b0);

    @(negedge clk);
    midstate_i = {8{32'hC0FFEE11}};
    nonce_first_i = 32'h20;
    nonce_last_i = 32'h23;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset.pre_found_valid", found_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset.busy", busy_o, 1'b0);
    chk("reset.done", done_o, 1'b0);
    chk("reset.found_valid", found_valid_o, 1'b0);
    chk("reset.found_nonce", found_nonce_o, 32'd0);
    chk("reset.overflow", overflow_o, 1'b0);
    chk("reset.pipe_data", pipe_data_o, 512'd0);
    chk("reset.pipe_state", pipe_state_o, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    seen_fv = 1'b0;
    seen_busy = 1'b0;
    repeat (2 * PL + 4) begin
      @(negedge clk);
      seen_done |= done_o;
      seen_fv |= found_valid_o;
      seen_busy |= busy_o;
    end
    chk("reset.no_done", seen_done, 1'b0);
    chk("reset.no_hits", seen_fv, 1'b0);
    chk("reset.no_busy", seen_busy, 1'b0);
    force_all = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
